// File: rtl/uart_arb_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM state encoding and
// counter widths used by the burst limiter and the handshake watchdog.
package uart_arb_pkg;

  localparam int N_STATES = 7;
  localparam int TMO_W    = 16;
  localparam int BURST_W  = 8;

  typedef enum logic [N_STATES-1:0] {
    S_IDLE = 7'b0000001,
    S_ARB  = 7'b0000010,
    S_RD   = 7'b0000100,
    S_LAT  = 7'b0001000,
    S_LOAD = 7'b0010000,
    S_ACK  = 7'b0100000,
    S_DONE = 7'b1000000
  } state_e;

endpackage

// File: rtl/uart_tx_arbiter_sync2.sv
// Two-flop synchroniser for level signals arriving from another clock domain;
// the reset value is chosen per instance so downstream logic starts in a safe state.
module sync2 #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk_24m,
  input  logic         rstn,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk_24m or negedge rstn) begin
    if (!rstn) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one byte-wide UART transmitter between NCH FIFOs with 1-cycle read latency,
// using fixed-priority or round-robin selection, a per-grant burst limit and a watchdog.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NCH   = 3,
  parameter int BURST = 4,
  parameter int TMO   = 4095
) (
  input  logic             clk_24m,
  input  logic             rstn,
  input  logic             rr_mode_i,
  input  logic [NCH-1:0]   ch_empty_i,
  input  logic [8*NCH-1:0] ch_data_i,
  output logic [NCH-1:0]   ch_rden_o,
  input  logic             tx_idle_i,
  output logic             tx_start_o,
  output logic [7:0]       tx_data_o,
  output logic [NCH-1:0]   grant_o,
  output logic             tmo_err_o
);

  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

  state_e             state_q,    state_d;
  logic [NCH-1:0]     grant_q,    grant_d;
  logic [IW-1:0]      gidx_q,     gidx_d;
  logic [IW-1:0]      rr_ptr_q,   rr_ptr_d;
  logic [BURST_W-1:0] burst_q,    burst_d;
  logic [TMO_W-1:0]   wdog_q,     wdog_d;
  logic [NCH-1:0]     rden_q,     rden_d;
  logic               tx_start_q, tx_start_d;
  logic [7:0]         tx_data_q,  tx_data_d;
  logic               tmo_err_q,  tmo_err_d;

  logic [NCH-1:0] empty_s;
  logic           idle_s;
  logic [NCH-1:0] req;
  logic [IW-1:0]  pick;
  logic [7:0]     ch_byte [NCH];

  // Empty flags reset to 1 so no channel requests until the FIFOs are actually seen.
  sync2 #(.W(NCH), .RST_VAL({NCH{1'b1}})) u_sync_empty (
    .clk_24m (clk_24m),
    .rstn    (rstn),
    .d_i     (ch_empty_i),
    .q_o     (empty_s)
  );

  sync2 #(.W(1), .RST_VAL(1'b0)) u_sync_idle (
    .clk_24m (clk_24m),
    .rstn    (rstn),
    .d_i     (tx_idle_i),
    .q_o     (idle_s)
  );

  assign req = ~empty_s;

  for (genvar gi = 0; gi < NCH; gi++) begin : g_byte
    assign ch_byte[gi] = ch_data_i[8*gi +: 8];
  end

  function automatic logic [IW-1:0] fx_pick(input logic [NCH-1:0] r);
    logic [IW-1:0] p;
    p = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (r[k]) p = IW'(k);
    end
    return p;
  endfunction

  // Scan downwards so the candidate closest to ptr (wrapping) is the last one kept.
  function automatic logic [IW-1:0] rr_pick(input logic [NCH-1:0] r, input logic [IW-1:0] ptr);
    logic [IW-1:0] p;
    int            idx;
    p = ptr;
    for (int k = NCH - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NCH;
      if (r[idx]) p = IW'(idx);
    end
    return p;
  endfunction

  function automatic logic [NCH-1:0] onehot(input logic [IW-1:0] idx);
    logic [NCH-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    gidx_d     = gidx_q;
    rr_ptr_d   = rr_ptr_q;
    burst_d    = burst_q;
    wdog_d     = wdog_q;
    rden_d     = '0;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    tmo_err_d  = tmo_err_q;
    pick       = rr_mode_i ? rr_pick(req, rr_ptr_q) : fx_pick(req);

    unique case (state_q)
      S_IDLE: begin
        if (|req && idle_s) state_d = S_ARB;
      end
      S_ARB: begin
        if (|req) begin
          gidx_d  = pick;
          grant_d = onehot(pick);
          rden_d  = onehot(pick);
          burst_d = '0;
          state_d = S_RD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RD: begin
        state_d = S_LAT;
      end
      S_LAT: begin
        tx_data_d  = ch_byte[gidx_q];
        tx_start_d = 1'b1;
        state_d    = S_LOAD;
      end
      S_LOAD: begin
        burst_d = burst_q + 1'b1;
        wdog_d  = '0;
        state_d = S_ACK;
      end
      S_ACK: begin
        if (!idle_s) begin
          state_d = S_DONE;
        end else if (wdog_q >= TMO_W'(TMO)) begin
          // Byte is abandoned; the pointer stays put so this channel keeps its turn.
          tmo_err_d = 1'b1;
          grant_d   = '0;
          state_d   = S_IDLE;
        end else if (wdog_q != {TMO_W{1'b1}}) begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      S_DONE: begin
        if (idle_s) begin
          if (req[gidx_q] && (burst_q < BURST_W'(BURST))) begin
            rden_d  = grant_q;
            state_d = S_RD;
          end else begin
            grant_d  = '0;
            rr_ptr_d = (gidx_q == IW'(NCH - 1)) ? '0 : gidx_q + 1'b1;
            state_d  = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_24m or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      grant_q    <= '0;
      gidx_q     <= '0;
      rr_ptr_q   <= '0;
      burst_q    <= '0;
      wdog_q     <= '0;
      rden_q     <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
      tmo_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      gidx_q     <= gidx_d;
      rr_ptr_q   <= rr_ptr_d;
      burst_q    <= burst_d;
      wdog_q     <= wdog_d;
      rden_q     <= rden_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      tmo_err_q  <= tmo_err_d;
    end
  end

  assign ch_rden_o  = rden_q;
  assign tx_start_o = tx_start_q;
  assign tx_data_o  = tx_data_q;
  assign grant_o    = grant_q;
  assign tmo_err_o  = tmo_err_q;

endmodule
